// File: rtl/key_evt_pkg.sv
// Shared types and timing constants for the key event decoder.
package key_evt_pkg;

    // One-hot gesture states
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_PRESS1 = 5'b00010,
        S_WAIT2  = 5'b00100,
        S_PRESS2 = 5'b01000,
        S_LONG   = 5'b10000
    } evt_state_e;

    // Default timing at 50 MHz
    localparam int unsigned DEF_LONG_CNT   = 50_000_000; // 1 s
    localparam int unsigned DEF_DBL_CNT    = 15_000_000; // 300 ms
    localparam int unsigned DEF_REPEAT_CNT = 10_000_000; // 200 ms
    localparam int unsigned DEF_CNT_W      = 26;

    // Reduced timing for simulation
    localparam int unsigned SIM_LONG_CNT   = 20;
    localparam int unsigned SIM_DBL_CNT    = 10;
    localparam int unsigned SIM_REPEAT_CNT = 5;
    localparam int unsigned SIM_CNT_W      = 5;

endpackage

// File: rtl/key_evt_decode.sv
// Key gesture decoder: turns debounced key edges into click, double click,
// long press and auto-repeat pulses. Timer and FSM share one module because
// the timer clear is driven by FSM transitions.
module key_evt_decode
    import key_evt_pkg::*;
#(
    parameter int unsigned LONG_CNT   = DEF_LONG_CNT,
    parameter int unsigned DBL_CNT    = DEF_DBL_CNT,
    parameter int unsigned REPEAT_CNT = DEF_REPEAT_CNT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic key_state,
    input  logic key_flag,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CNT - 1);

    evt_state_e       state;
    evt_state_e       state_n;
    logic [CNT_W-1:0] timer;
    logic             timer_clr;
    logic             press_ev;
    logic             release_ev;
    logic             click_n;
    logic             double_click_n;
    logic             long_press_n;
    logic             repeat_pulse_n;

    assign press_ev   = key_flag & ~key_state;
    assign release_ev = key_flag &  key_state;

    // Next-state and pulse decode; key events take priority over timeouts
    always_comb begin
        state_n        = state;
        timer_clr      = 1'b0;
        click_n        = 1'b0;
        double_click_n = 1'b0;
        long_press_n   = 1'b0;
        repeat_pulse_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_ev)
                    state_n = S_PRESS1;
            end
            S_PRESS1: begin
                if (release_ev) begin
                    state_n = S_WAIT2;
                end else if (timer == LONG_LIM) begin
                    state_n      = S_LONG;
                    long_press_n = 1'b1;
                end
            end
            S_WAIT2: begin
                if (press_ev) begin
                    state_n = S_PRESS2;
                end else if (timer == DBL_LIM) begin
                    state_n = S_IDLE;
                    click_n = 1'b1;
                end
            end
            S_PRESS2: begin
                if (release_ev) begin
                    state_n        = S_IDLE;
                    double_click_n = 1'b1;
                end else if (timer == LONG_LIM) begin
                    state_n      = S_LONG;
                    long_press_n = 1'b1;
                end
            end
            S_LONG: begin
                if (release_ev) begin
                    state_n = S_IDLE;
                end else if (timer == REP_LIM) begin
                    timer_clr      = 1'b1;
                    repeat_pulse_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, shared timer and registered outputs; timer is parked at 0 in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            click        <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state || timer_clr || state == S_IDLE)
                timer <= '0;
            else
                timer <= timer + CNT_W'(1);
            click        <= click_n;
            double_click <= double_click_n;
            long_press   <= long_press_n;
            repeat_pulse <= repeat_pulse_n;
            busy         <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_key_evt_decode.sv
// Self-checking bench for key_evt_decode: directed gesture scenarios plus
// random key activity, all compared cycle by cycle against a timestamp model.
module tb_key_evt_decode;

    localparam int unsigned T_LONG = 20;
    localparam int unsigned T_DBL  = 10;
    localparam int unsigned T_REP  = 5;

    logic clk;
    logic reset;
    logic key_state;
    logic key_flag;
    logic click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Gesture model: tracks held/released and cycles since the last anchor edge
    bit m_active, m_held, m_long;
    int m_npress, m_age;
    bit e_click, e_dbl, e_long, e_rep;

    // Per-scenario tallies of DUT pulses, indexed by edge number
    int edge_no;
    int cnt_click, cnt_dbl, cnt_long, cnt_rep;
    int click_edge, dbl_edge, long_edge, rep_first, rep_last;

    key_evt_decode #(
        .LONG_CNT   (T_LONG),
        .DBL_CNT    (T_DBL),
        .REPEAT_CNT (T_REP),
        .CNT_W      (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_state    (key_state),
        .key_flag     (key_flag),
        .click        (click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_held = 0; m_long = 0; m_npress = 0; m_age = 0;
        e_click = 0; e_dbl = 0; e_long = 0; e_rep = 0;
    endtask

    task automatic model_step(input bit p, input bit r);
        e_click = 0; e_dbl = 0; e_long = 0; e_rep = 0;
        if (!m_active) begin
            if (p) begin
                m_active = 1; m_held = 1; m_long = 0; m_npress = 1; m_age = 0;
            end
        end else begin
            m_age++;
            if (m_long) begin
                if (r) m_active = 0;
                else if (m_age % T_REP == 0) e_rep = 1;
            end else if (m_held) begin
                if (r) begin
                    if (m_npress == 2) begin
                        e_dbl = 1; m_active = 0;
                    end else begin
                        m_held = 0; m_age = 0;
                    end
                end else if (m_age == T_LONG) begin
                    e_long = 1; m_long = 1; m_age = 0;
                end
            end else begin
                if (p) begin
                    m_held = 1; m_npress = 2; m_age = 0;
                end else if (m_age == T_DBL) begin
                    e_click = 1; m_active = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("click", click, e_click);
        check_eq("double_click", double_click, e_dbl);
        check_eq("long_press", long_press, e_long);
        check_eq("repeat_pulse", repeat_pulse, e_rep);
        check_eq("busy", busy, m_active);
        check_eq("onehot", ($countones({click, double_click, long_press, repeat_pulse}) <= 1), 1);
        if (click)        begin cnt_click++; click_edge = edge_no; end
        if (double_click) begin cnt_dbl++;   dbl_edge   = edge_no; end
        if (long_press)   begin cnt_long++;  long_edge  = edge_no; end
        if (repeat_pulse) begin
            if (cnt_rep == 0) rep_first = edge_no;
            cnt_rep++; rep_last = edge_no;
        end
    endtask

    task automatic tick(input bit flag);
        key_flag = flag;
        @(posedge clk);
        model_step(flag & ~key_state, flag & key_state);
        edge_no++;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic key_ev(input bit press);
        key_state = press ? 1'b0 : 1'b1;
        tick(1'b1);
        key_flag = 1'b0;
    endtask

    task automatic start_scen();
        edge_no = -1;
        cnt_click = 0; cnt_dbl = 0; cnt_long = 0; cnt_rep = 0;
        click_edge = -1; dbl_edge = -1; long_edge = -1; rep_first = -1; rep_last = -1;
    endtask

    task automatic apply_reset();
        key_flag = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        reset = 1'b1;
    endtask

    initial begin
        bit press;
        int g;
        reset = 1'b0;
        key_state = 1'b1;
        key_flag = 1'b0;
        model_reset();
        start_scen();
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pulses", {click, double_click, long_press, repeat_pulse}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single click
        start_scen();
        key_ev(1); idle(4); key_ev(0); idle(15);
        check_eq("s1_click_cnt", cnt_click, 1);
        check_eq("s1_click_edge", click_edge, 15);
        check_eq("s1_other", cnt_dbl + cnt_long + cnt_rep, 0);

        // Double click
        start_scen();
        key_ev(1); idle(2); key_ev(0); idle(3); key_ev(1); idle(2); key_ev(0); idle(12);
        check_eq("s2_dbl_cnt", cnt_dbl, 1);
        check_eq("s2_dbl_edge", dbl_edge, 10);
        check_eq("s2_click_cnt", cnt_click, 0);

        // Long press with repeat
        start_scen();
        key_ev(1); idle(41); key_ev(0); idle(12);
        check_eq("s3_long_edge", long_edge, 20);
        check_eq("s3_rep_cnt", cnt_rep, 4);
        check_eq("s3_rep_first", rep_first, 25);
        check_eq("s3_rep_last", rep_last, 40);
        check_eq("s3_click_cnt", cnt_click + cnt_dbl, 0);

        // Release on the long-press boundary
        start_scen();
        key_ev(1); idle(19); key_ev(0); idle(12);
        check_eq("s4_long_cnt", cnt_long, 0);
        check_eq("s4_click_edge", click_edge, 30);

        // Second press on the double-click boundary
        start_scen();
        key_ev(1); idle(1); key_ev(0); idle(9); key_ev(1); idle(2); key_ev(0); idle(12);
        check_eq("s5_click_cnt", cnt_click, 0);
        check_eq("s5_dbl_edge", dbl_edge, 15);

        // Reset mid-gesture
        start_scen();
        key_ev(1); idle(2); key_ev(0); idle(2);
        apply_reset();
        idle(15);
        check_eq("s6_click_cnt", cnt_click, 0);
        check_eq("s6_busy", busy, 0);
        start_scen();
        key_ev(1); idle(4); key_ev(0); idle(15);
        check_eq("s6b_click_edge", click_edge, 15);

        // Random key activity with occasional bounce-like repeats and resets
        for (int i = 0; i < 150; i++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 60)) : int'($urandom_range(1, 14));
            idle(g - 1);
            if ($urandom_range(0, 9) == 0) press = (key_state == 1'b0);
            else                           press = (key_state == 1'b1);
            key_ev(press);
            if ($urandom_range(0, 49) == 0) apply_reset();
        end
        idle(80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
